// File: rtl/timed_cmd_dispatcher_if.sv
// Dispatcher-facing bundle: command FIFO pop handshake, global clock
// input, pin-controller command bus and status.
// master: the dispatcher. slave: FIFO / global clock / bus side.
interface timed_cmd_dispatcher_if #(
    parameter int unsigned TW = 32,
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 32
);
    logic [TW-1:0] current_time;
    logic [79:0]   cmd_fifo_dout;
    logic          cmd_fifo_empty;
    logic          cmd_fifo_valid;
    logic          cmd_fifo_rd_en;
    logic [AW-1:0] cmd_bus_addr;
    logic [DW-1:0] cmd_bus_data;
    logic          cmd_bus_en;
    logic          cmd_bus_wr;
    logic          reset_time;
    logic          busy;

    modport master (
        input  current_time,
        input  cmd_fifo_dout,
        input  cmd_fifo_empty,
        input  cmd_fifo_valid,
        output cmd_fifo_rd_en,
        output cmd_bus_addr,
        output cmd_bus_data,
        output cmd_bus_en,
        output cmd_bus_wr,
        output reset_time,
        output busy
    );

    modport slave (
        output current_time,
        output cmd_fifo_dout,
        output cmd_fifo_empty,
        output cmd_fifo_valid,
        input  cmd_fifo_rd_en,
        input  cmd_bus_addr,
        input  cmd_bus_data,
        input  cmd_bus_en,
        input  cmd_bus_wr,
        input  reset_time,
        input  busy
    );
endinterface

// File: rtl/timed_cmd_dispatcher.sv
// Timed command dispatcher: pops one {time, addr, data} entry at a time
// from the command FIFO, holds it until the global clock reaches its start
// time, then issues a one-cycle bus write, or a one-cycle global-clock reset
// pulse when the entry address is RST_ADDR.
// Optional statistics counters (issued_count, late_count) are built when
// the macro DISPATCH_STATS_EN is defined.
module timed_cmd_dispatcher #(
    parameter int unsigned TW       = 32,
    parameter int unsigned AW       = 19,
    parameter int unsigned DW       = 32,
    parameter logic [15:0] RST_ADDR = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    timed_cmd_dispatcher_if.master io
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]            issued_count,
    output logic [31:0]            late_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [15:0]   a_q, a_d;
    logic [31:0]   d_q, d_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // Modular lag of the clock behind the held start time; MSB clear means
    // the start time is now or already in the past (within half the range).
    logic [TW-1:0] diff;
    logic          due;
    logic          is_rst_entry;

    assign diff         = io.current_time - t_q;
    assign due          = ~diff[TW-1];
    assign is_rst_entry = (a_q == RST_ADDR);

    // State, held command and bus output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            d_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            d_q     <= d_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; bus addr/data are only refreshed on the way into a
    // normal ISSUE so they hold their last values between strobes.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        d_d     = d_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!io.cmd_fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (io.cmd_fifo_valid) begin
                    t_d     = io.cmd_fifo_dout[48 +: TW];
                    a_d     = io.cmd_fifo_dout[47:32];
                    d_d     = io.cmd_fifo_dout[31:0];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (due) begin
                    state_d = S_ISSUE;
                    if (!is_rst_entry) begin
                        addr_d = AW'(a_q);
                        data_d = DW'(d_q);
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses decode straight from the registered state so reset clears them
    // immediately.
    assign io.cmd_fifo_rd_en = (state_q == S_FETCH);
    assign io.cmd_bus_en     = (state_q == S_ISSUE) && !is_rst_entry;
    assign io.cmd_bus_wr     = (state_q == S_ISSUE) && !is_rst_entry;
    assign io.reset_time     = (state_q == S_ISSUE) && is_rst_entry;
    assign io.busy           = (state_q != S_IDLE);
    assign io.cmd_bus_addr   = addr_q;
    assign io.cmd_bus_data   = data_q;

`ifdef DISPATCH_STATS_EN
    logic        first_wait_q;
    logic [31:0] issued_q;
    logic [31:0] late_q;
    logic        late_hit;

    // Late means already past the start time on the very first WAIT cycle.
    assign late_hit = (state_q == S_WAIT) && first_wait_q && due && (diff != '0);

    // Dispatch statistics; both counters wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_wait_q <= 1'b0;
            issued_q     <= '0;
            late_q       <= '0;
        end else begin
            first_wait_q <= (state_q == S_LOAD) && io.cmd_fifo_valid;
            if (state_q == S_ISSUE) begin
                issued_q <= issued_q + 32'd1;
            end
            if (late_hit) begin
                late_q <= late_q + 32'd1;
            end
        end
    end

    assign issued_count = issued_q;
    assign late_count   = late_q;
`endif

endmodule

// File: tb/tb_timed_cmd_dispatcher.sv
// Scoreboard bench for timed_cmd_dispatcher: a FIFO/global-clock model
// feeds the DUT; each popped entry gets its predicted strobe (kind, clock
// value, addr/data, stats) queued, and a monitor checks every strobe.
module tb_timed_cmd_dispatcher;

    localparam int unsigned TW       = 32;
    localparam int unsigned AW       = 19;
    localparam int unsigned DW       = 32;
    localparam logic [15:0] RST_ADDR = 16'hFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timed_cmd_dispatcher_if #(.TW(TW), .AW(AW), .DW(DW)) dif ();

`ifdef DISPATCH_STATS_EN
    logic [31:0] issued_count;
    logic [31:0] late_count;
`endif

    timed_cmd_dispatcher #(
        .TW(TW), .AW(AW), .DW(DW), .RST_ADDR(RST_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .io  (dif)
`ifdef DISPATCH_STATS_EN
        ,
        .issued_count (issued_count),
        .late_count   (late_count)
`endif
    );

    typedef struct {
        logic [31:0] t;
        logic [15:0] a;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        logic        is_rst;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] ct;
        int unsigned issued_before;
        int unsigned late_cum;
    } exp_t;

    cmd_t fifo_q[$];
    exp_t exp_q[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ct          = '0;
    logic        rt_prev     = 1'b0;
    logic        ct_load     = 1'b0;
    logic [31:0] ct_load_val = '0;
    int          load_phase  = 0;
    int          pops        = 0;
    int unsigned exp_issued  = 0;
    int unsigned exp_late    = 0;
    logic [15:0] last_addr   = '0;
    logic [31:0] last_data   = '0;
    cmd_t        pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference rule: the entry reaches WAIT two cycles after its FETCH.
    // If its start time is not in the future then (signed lag >= 0) it
    // strobes on the next cycle; otherwise it strobes one tick after the
    // clock reads its start time.
    function automatic exp_t predict(input cmd_t c, input logic [31:0] ct_fetch);
        exp_t e;
        int   lag;
        logic [31:0] wait_ct;
        wait_ct = ct_fetch + 32'd2;
        lag     = int'(wait_ct - c.t);
        e.is_rst = (c.a == RST_ADDR);
        e.a = c.a;
        e.d = c.d;
        e.issued_before = exp_issued;
        if (lag >= 0) begin
            e.ct = wait_ct + 32'd1;
            if (lag > 0) exp_late++;
        end else begin
            e.ct = c.t + 32'd1;
        end
        e.late_cum = exp_late;
        exp_issued++;
        return e;
    endfunction

    // FIFO and global clock model, updated just after each rising edge.
    initial begin
        dif.current_time   = '0;
        dif.cmd_fifo_dout  = '0;
        dif.cmd_fifo_empty = 1'b1;
        dif.cmd_fifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ct_load) begin
                ct      = ct_load_val;
                ct_load = 1'b0;
            end else if (rt_prev) begin
                ct = '0;
            end else begin
                ct = ct + 32'd1;
            end
            rt_prev = dif.reset_time;
            dif.current_time   = ct;
            dif.cmd_fifo_valid = 1'b0;
            if (load_phase == 1) begin
                dif.cmd_fifo_valid = 1'b1;
                dif.cmd_fifo_dout  = {pend.t, pend.a, pend.d};
                load_phase = 0;
            end
            if (dif.cmd_fifo_rd_en) begin
                pops++;
                chk("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
                if (fifo_q.size() != 0) begin
                    pend = fifo_q.pop_front();
                    exp_q.push_back(predict(pend, ct));
                    load_phase = 1;
                end
            end
            dif.cmd_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: compares each strobe against the scoreboard head and checks
    // that addr/data hold between strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("wr_eq_en", 64'(dif.cmd_bus_wr), 64'(dif.cmd_bus_en));
                if (dif.cmd_bus_en || dif.reset_time) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 64'(dif.cmd_bus_en | dif.reset_time), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_en", 64'(dif.cmd_bus_en), 64'(!e.is_rst));
                        chk("strobe_reset_time", 64'(dif.reset_time), 64'(e.is_rst));
                        chk("strobe_time", 64'(dif.current_time), 64'(e.ct));
                        if (!e.is_rst) begin
                            last_addr = e.a;
                            last_data = e.d;
                        end
`ifdef DISPATCH_STATS_EN
                        chk("issued_count", 64'(issued_count), 64'(e.issued_before));
                        chk("late_count", 64'(late_count), 64'(e.late_cum));
`endif
                    end
                end
                chk("bus_addr", 64'(dif.cmd_bus_addr), 64'(last_addr));
                chk("bus_data", 64'(dif.cmd_bus_data), 64'(last_data));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},      64'(dif.cmd_bus_en), 64'd0);
        chk({tag, "_wr"},      64'(dif.cmd_bus_wr), 64'd0);
        chk({tag, "_rst_t"},   64'(dif.reset_time), 64'd0);
        chk({tag, "_rd_en"},   64'(dif.cmd_fifo_rd_en), 64'd0);
        chk({tag, "_busy"},    64'(dif.busy), 64'd0);
        chk({tag, "_addr"},    64'(dif.cmd_bus_addr), 64'd0);
        chk({tag, "_data"},    64'(dif.cmd_bus_data), 64'd0);
`ifdef DISPATCH_STATS_EN
        chk({tag, "_issued"},  64'(issued_count), 64'd0);
        chk({tag, "_late"},    64'(late_count), 64'd0);
`endif
    endtask

    task automatic set_time(input logic [31:0] v);
        @(negedge clk);
        ct_load_val = v;
        ct_load     = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] t, input logic [15:0] a, input logic [31:0] d);
        cmd_t c;
        c.t = t;
        c.a = a;
        c.d = d;
        fifo_q.push_back(c);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || dif.busy || load_phase != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= limit), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pops_at_release;
        int unsigned n;
        logic [15:0] ra;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Future entry: strobe one tick after its start time.
        set_time(32'd0);
        push(32'd100, 16'd5, 32'hDEAD_BEEF);
        drain(3000);

        // Entry already in the past: issues without waiting, counted late.
        set_time(32'd500);
        push(32'd10, 16'h0123, 32'h1111_2222);
        drain(3000);

        // Clock-reset entry followed by an entry relative to the new epoch.
        set_time(32'd0);
        push(32'd20, RST_ADDR, 32'hAAAA_5555);
        push(32'd3, 16'h0042, 32'h0000_0042);
        drain(3000);

        // Out-of-order times issue strictly in FIFO order.
        set_time(32'd0);
        push(32'd50, 16'd1, 32'h0000_0050);
        push(32'd40, 16'd2, 32'h0000_0040);
        push(32'd60, 16'd3, 32'h0000_0060);
        drain(3000);

        // Start time just past the clock wrap.
        set_time(32'hFFFF_FFF0);
        push(32'h0000_0008, 16'h7777, 32'hCAFE_F00D);
        drain(3000);

        // Reset while holding a far-future entry: discarded, never re-popped.
        set_time(32'd0);
        push(32'd1000, 16'h0321, 32'h5A5A_5A5A);
        repeat (10) @(negedge clk);
        chk("busy_in_wait", 64'(dif.busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_issued = 0;
        exp_late   = 0;
        last_addr  = '0;
        last_data  = '0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pops_at_release = pops;
        while (ct < 32'd1020) @(negedge clk);
        chk("no_repop", 64'(pops), 64'(pops_at_release));
        chk("idle_after_reset", 64'(dif.busy), 64'd0);

        // Randomized groups around the current clock, some clock-reset entries.
        for (int g = 0; g < 12; g++) begin
            if ($urandom_range(0, 3) == 0) set_time($urandom);
            n = $urandom_range(1, 4);
            for (int unsigned k = 0; k < n; k++) begin
                ra = ($urandom_range(0, 5) == 0) ? RST_ADDR : 16'($urandom);
                push(ct + 32'($urandom_range(0, 80)) - 32'd25, ra, $urandom);
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
            drain(3000);
        end

`ifdef DISPATCH_STATS_EN
        chk("final_issued", 64'(issued_count), 64'(exp_issued));
        chk("final_late", 64'(late_count), 64'(exp_late));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
